// File: rtl/nrzi_rx_decoder.sv
// Low-speed USB receive front end: samples D+/D- once per bit time, NRZI-decodes,
// removes stuffed bits, recognises SYNC and EOP, and assembles LSB-first bytes
// with packet framing (rxActive, rxEop) and coded error pulses for the PID parser.
module nrzi_rx_decoder #(
    parameter int         STUFF_LEN    = 6,
    parameter int         EOP_SE0_MAX  = 3,
    parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
    input  logic       useClk,
    input  logic       rst,
    input  logic       checkData,
    input  logic       dp,
    input  logic       dm,
    output logic       rxActive,
    output logic [7:0] rxByte,
    output logic       rxByteValid,
    output logic       rxEop,
    output logic       rxErr,
    output logic [1:0] rxErrCode,
    output logic [3:0] rxByteCount
);

    localparam int SW = $clog2(STUFF_LEN + 1);
    localparam int EW = $clog2(EOP_SE0_MAX + 2);
    localparam logic [SW-1:0] STUFF_LIM = SW'(STUFF_LEN);
    localparam logic [EW-1:0] SE0_LIM   = EW'(EOP_SE0_MAX);

    localparam logic [1:0] CODE_STUFF   = 2'd0;
    localparam logic [1:0] CODE_SYNC    = 2'd1;
    localparam logic [1:0] CODE_PARTIAL = 2'd2;
    localparam logic [1:0] CODE_LINE    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          prev_k_q, prev_k_d;       // 1 when the last J/K sample was K
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] stuff_cnt_q, stuff_cnt_d;
    logic [EW-1:0] se0_cnt_q, se0_cnt_d;
    logic          partial_q, partial_d;
    logic          j_cnt_q, j_cnt_d;         // J samples seen so far while in ERR
    logic          rx_active_q, rx_active_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_byte_valid_q, rx_byte_valid_d;
    logic          rx_eop_q, rx_eop_d;
    logic          rx_err_q, rx_err_d;
    logic [1:0]    rx_err_code_q, rx_err_code_d;
    logic [3:0]    rx_byte_count_q, rx_byte_count_d;

    logic          line_j, line_k, line_se0, line_se1;
    logic          dec_bit;
    logic [7:0]    shift_in;
    logic [EW-1:0] se0_inc;
    logic          go_err;
    logic [1:0]    err_code;

    // Line classification, NRZI decode and next-state / output computation.
    always_comb begin
        line_j   = ~dp &  dm;
        line_k   =  dp & ~dm;
        line_se0 = ~dp & ~dm;
        line_se1 =  dp &  dm;
        // No transition decodes as 1, a transition as 0.
        dec_bit  = ~(line_k ^ prev_k_q);
        shift_in = {dec_bit, shift_q[7:1]};
        se0_inc  = se0_cnt_q + 1'b1;
        go_err   = 1'b0;
        err_code = CODE_STUFF;

        state_d         = state_q;
        prev_k_d        = prev_k_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        stuff_cnt_d     = stuff_cnt_q;
        se0_cnt_d       = se0_cnt_q;
        partial_d       = partial_q;
        j_cnt_d         = j_cnt_q;
        rx_active_d     = rx_active_q;
        rx_byte_d       = rx_byte_q;
        rx_byte_valid_d = 1'b0;
        rx_eop_d        = 1'b0;
        rx_err_d        = 1'b0;
        rx_err_code_d   = rx_err_code_q;
        rx_byte_count_d = rx_byte_count_q;

        if (checkData) begin
            if (line_j || line_k) begin
                prev_k_d = line_k;
            end

            case (state_q)
                ST_IDLE: begin
                    // The first K is the first SYNC bit (a decoded 0).
                    if (line_k) begin
                        shift_d   = 8'h00;
                        bit_cnt_d = 3'd1;
                        state_d   = ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (line_se0 || line_se1) begin
                        go_err   = 1'b1;
                        err_code = CODE_SYNC;
                    end else begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_in == SYNC_PATTERN) begin
                                rx_active_d     = 1'b1;
                                // SYNC ends in a decoded 1, which starts the stuffing run.
                                stuff_cnt_d     = SW'(1);
                                rx_byte_count_d = 4'd0;
                                state_d         = ST_DATA;
                            end else begin
                                go_err   = 1'b1;
                                err_code = CODE_SYNC;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    // SE0 wins over a pending stuffed-bit check.
                    if (line_se0) begin
                        se0_cnt_d = EW'(1);
                        partial_d = (bit_cnt_q != 3'd0);
                        state_d   = ST_EOP;
                    end else if (line_se1) begin
                        go_err   = 1'b1;
                        err_code = CODE_LINE;
                    end else if (stuff_cnt_q == STUFF_LIM) begin
                        if (dec_bit) begin
                            go_err   = 1'b1;
                            err_code = CODE_STUFF;
                        end else begin
                            stuff_cnt_d = '0;
                        end
                    end else begin
                        shift_d     = shift_in;
                        stuff_cnt_d = dec_bit ? stuff_cnt_q + 1'b1 : '0;
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d       = shift_in;
                            rx_byte_valid_d = 1'b1;
                            if (rx_byte_count_q != 4'hF) begin
                                rx_byte_count_d = rx_byte_count_q + 4'd1;
                            end
                        end
                    end
                end

                ST_EOP: begin
                    if (line_se0) begin
                        if (se0_inc > SE0_LIM) begin
                            go_err   = 1'b1;
                            err_code = CODE_LINE;
                        end else begin
                            se0_cnt_d = se0_inc;
                        end
                    end else if (line_j) begin
                        if (partial_q) begin
                            rx_err_d      = 1'b1;
                            rx_err_code_d = CODE_PARTIAL;
                        end else begin
                            rx_eop_d = 1'b1;
                        end
                        rx_active_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        go_err   = 1'b1;
                        err_code = CODE_LINE;
                    end
                end

                ST_ERR: begin
                    // Two consecutive J samples mean the line is idle again.
                    if (line_j) begin
                        if (j_cnt_q) begin
                            j_cnt_d = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            j_cnt_d = 1'b1;
                        end
                    end else begin
                        j_cnt_d = 1'b0;
                    end
                end

                default: state_d = ST_IDLE;
            endcase

            if (go_err) begin
                state_d       = ST_ERR;
                rx_err_d      = 1'b1;
                rx_err_code_d = err_code;
                rx_active_d   = 1'b0;
                j_cnt_d       = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge useClk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            prev_k_q        <= 1'b0;
            shift_q         <= 8'h00;
            bit_cnt_q       <= 3'd0;
            stuff_cnt_q     <= '0;
            se0_cnt_q       <= '0;
            partial_q       <= 1'b0;
            j_cnt_q         <= 1'b0;
            rx_active_q     <= 1'b0;
            rx_byte_q       <= 8'h00;
            rx_byte_valid_q <= 1'b0;
            rx_eop_q        <= 1'b0;
            rx_err_q        <= 1'b0;
            rx_err_code_q   <= 2'd0;
            rx_byte_count_q <= 4'd0;
        end else begin
            state_q         <= state_d;
            prev_k_q        <= prev_k_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            stuff_cnt_q     <= stuff_cnt_d;
            se0_cnt_q       <= se0_cnt_d;
            partial_q       <= partial_d;
            j_cnt_q         <= j_cnt_d;
            rx_active_q     <= rx_active_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            rx_eop_q        <= rx_eop_d;
            rx_err_q        <= rx_err_d;
            rx_err_code_q   <= rx_err_code_d;
            rx_byte_count_q <= rx_byte_count_d;
        end
    end

    assign rxActive    = rx_active_q;
    assign rxByte      = rx_byte_q;
    assign rxByteValid = rx_byte_valid_q;
    assign rxEop       = rx_eop_q;
    assign rxErr       = rx_err_q;
    assign rxErrCode   = rx_err_code_q;
    assign rxByteCount = rx_byte_count_q;

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Bench for nrzi_rx_decoder: table-driven ACK packet (back-to-back and with
// strobe gaps) plus hand-written sequences for stuffing, bad SYNC, partial
// byte, long SE0 and reset in the middle of a packet.
module tb_nrzi_rx_decoder;

    logic       useClk;
    logic       rst;
    logic       checkData;
    logic       dp;
    logic       dm;
    logic       rxActive;
    logic [7:0] rxByte;
    logic       rxByteValid;
    logic       rxEop;
    logic       rxErr;
    logic [1:0] rxErrCode;
    logic [3:0] rxByteCount;

    nrzi_rx_decoder dut (
        .useClk      (useClk),
        .rst         (rst),
        .checkData   (checkData),
        .dp          (dp),
        .dm          (dm),
        .rxActive    (rxActive),
        .rxByte      (rxByte),
        .rxByteValid (rxByteValid),
        .rxEop       (rxEop),
        .rxErr       (rxErr),
        .rxErrCode   (rxErrCode),
        .rxByteCount (rxByteCount)
    );

    initial useClk = 1'b0;
    always #5 useClk = ~useClk;

    localparam logic [1:0] LJ  = 2'b01;   // {dp, dm}
    localparam logic [1:0] LK  = 2'b10;
    localparam logic [1:0] LS0 = 2'b00;

    typedef struct {
        logic [1:0] ln;
        logic       act;
        logic [7:0] byt;
        logic       vld;
        logic       eop;
        logic       err;
        logic [1:0] code;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [21];

    int n_vec = 0;
    int n_bad = 0;

    // Observation log filled in by every strobe.
    logic [7:0] bytes [$];
    int         eop_n;
    int         err_n;
    int         both_n;
    logic [1:0] last_code;
    logic       line_k;   // bench's NRZI encoder line state (1 = K)

    function automatic vec_t mkv(logic [1:0] ln, logic act, logic [7:0] byt, logic vld,
                                 logic eop, logic err, logic [1:0] code, logic [3:0] cnt);
        vec_t v;
        v.ln = ln; v.act = act; v.byt = byt; v.vld = vld;
        v.eop = eop; v.err = err; v.code = code; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [17:0] pack_exp(vec_t v, logic pulses);
        return {v.act, v.byt, v.vld & pulses, v.eop & pulses, v.err & pulses,
                pulses ? v.code : 2'b00, v.cnt};
    endfunction

    function automatic logic [17:0] out_now();
        return {rxActive, rxByte, rxByteValid, rxEop, rxErr,
                rxErr ? rxErrCode : 2'b00, rxByteCount};
    endfunction

    function automatic logic [7:0] byte_at(int i);
        if (bytes.size() > i) return bytes[i];
        return 8'hxx;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic clr_log();
        bytes.delete();
        eop_n = 0; err_n = 0; both_n = 0; last_code = 2'd0;
    endtask

    task automatic log_outputs();
        if (rxByteValid) bytes.push_back(rxByte);
        if (rxEop) eop_n++;
        if (rxErr) begin err_n++; last_code = rxErrCode; end
        if (rxEop && rxErr) both_n++;
    endtask

    // One bit-time sample, outputs inspected 1 time unit after the edge.
    task automatic strobe(input logic [1:0] ln);
        {dp, dm} = ln;
        checkData = 1'b1;
        @(posedge useClk); #1;
        checkData = 1'b0;
        log_outputs();
    endtask

    task automatic send_j();   strobe(LJ);  line_k = 1'b0; endtask
    task automatic send_k();   strobe(LK);  line_k = 1'b1; endtask
    task automatic send_se0(); strobe(LS0); endtask

    task automatic send_bit(input logic b);
        if (b ^ line_k) send_j(); else send_k();
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
    endtask

    task automatic send_sync();
        send_bits(32'h80, 8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        checkData = 1'b0;
        {dp, dm} = LJ;
        @(posedge useClk); #1;
        rst = 1'b0;
        line_k = 1'b0;
        clr_log();
    endtask

    task automatic run_table(input logic gaps);
        for (int i = 0; i < 21; i++) begin
            strobe(tbl[i].ln);
            chk($sformatf("ack%s[%0d]", gaps ? "_gap" : "", i), 32'(out_now()), 32'(pack_exp(tbl[i], 1'b1)));
            if (gaps) begin
                for (int g = 0; g < 3; g++) begin
                    @(posedge useClk); #1;
                    chk($sformatf("ack_gap[%0d]+%0d", i, g), 32'(out_now()), 32'(pack_exp(tbl[i], 1'b0)));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ACK packet: idle J, SYNC KJKJKJKK, PID 0xD2 (J J K J J K K K), SE0 SE0 J, J.
        tbl[0]  = mkv(LJ,  0, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[1]  = mkv(LK,  0, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[2]  = mkv(LJ,  0, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[3]  = mkv(LK,  0, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[4]  = mkv(LJ,  0, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[5]  = mkv(LK,  0, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[6]  = mkv(LJ,  0, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[7]  = mkv(LK,  0, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[8]  = mkv(LK,  1, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[9]  = mkv(LJ,  1, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[10] = mkv(LJ,  1, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[11] = mkv(LK,  1, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[12] = mkv(LJ,  1, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[13] = mkv(LJ,  1, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[14] = mkv(LK,  1, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[15] = mkv(LK,  1, 8'h00, 0, 0, 0, 2'd0, 4'd0);
        tbl[16] = mkv(LK,  1, 8'hD2, 1, 0, 0, 2'd0, 4'd1);
        tbl[17] = mkv(LS0, 1, 8'hD2, 0, 0, 0, 2'd0, 4'd1);
        tbl[18] = mkv(LS0, 1, 8'hD2, 0, 0, 0, 2'd0, 4'd1);
        tbl[19] = mkv(LJ,  0, 8'hD2, 0, 1, 0, 2'd0, 4'd1);
        tbl[20] = mkv(LJ,  0, 8'hD2, 0, 0, 0, 2'd0, 4'd1);

        rst = 1'b1;
        checkData = 1'b0;
        {dp, dm} = LJ;
        line_k = 1'b0;
        clr_log();
        repeat (3) @(posedge useClk);
        #1;
        chk("reset_outputs", 32'(out_now()), 32'h0);
        rst = 1'b0;

        // ACK packet with back-to-back strobes, then with 3-cycle gaps.
        run_table(1'b0);
        do_reset();
        run_table(1'b1);

        // Stuffing: 0xFF 0x01 with one stuffed 0 after the six-1 run.
        do_reset();
        send_j();
        send_sync();
        send_bits(32'h0000_03DF, 17);
        chk("stuff_active", 32'(rxActive), 32'd1);
        send_se0(); send_se0(); send_j();
        chk("stuff_nbytes", bytes.size(), 32'd2);
        chk("stuff_byte0", 32'(byte_at(0)), 32'hFF);
        chk("stuff_byte1", 32'(byte_at(1)), 32'h01);
        chk("stuff_errs", err_n, 32'd0);
        chk("stuff_eops", eop_n, 32'd1);
        chk("stuff_count", 32'(rxByteCount), 32'd2);
        chk("stuff_active_after", 32'(rxActive), 32'd0);

        // Missing stuffed bit: a 1 where the stuffed 0 belongs.
        do_reset();
        send_j();
        send_sync();
        send_bits(32'h3F, 6);
        chk("nostuff_err", err_n, 32'd1);
        chk("nostuff_code", 32'(last_code), 32'd0);
        chk("nostuff_active", 32'(rxActive), 32'd0);
        send_se0(); send_se0(); send_j(); send_j();
        chk("nostuff_eops", eop_n, 32'd0);
        chk("nostuff_bytes", bytes.size(), 32'd0);
        chk("nostuff_errs_end", err_n, 32'd1);

        // Bad SYNC, recovery after two J samples, then a valid ACK.
        do_reset();
        send_j();
        send_bits(32'h00, 8);
        chk("badsync_err", err_n, 32'd1);
        chk("badsync_code", 32'(last_code), 32'd1);
        send_bits(32'hD2, 8);
        chk("badsync_bytes", bytes.size(), 32'd0);
        chk("badsync_errs", err_n, 32'd1);
        send_sync();
        send_bits(32'hD2, 8);
        send_se0(); send_se0(); send_j();
        chk("recover_nbytes", bytes.size(), 32'd1);
        chk("recover_byte", 32'(byte_at(0)), 32'hD2);
        chk("recover_eop", eop_n, 32'd1);
        chk("recover_errs", err_n, 32'd1);

        // Partial byte at EOP.
        do_reset();
        send_j();
        send_sync();
        send_bits(32'h15, 5);
        send_se0(); send_se0(); send_j();
        chk("partial_err", err_n, 32'd1);
        chk("partial_code", 32'(last_code), 32'd2);
        chk("partial_eop", eop_n, 32'd0);
        chk("partial_bytes", bytes.size(), 32'd0);
        chk("partial_active", 32'(rxActive), 32'd0);

        // SE0 held too long: three SE0s are tolerated, the fourth is an error.
        clr_log();
        send_sync();
        send_bits(32'hD2, 8);
        send_se0(); send_se0(); send_se0();
        chk("se0x3_no_err", err_n, 32'd0);
        send_se0();
        chk("se0x4_err", err_n, 32'd1);
        chk("se0x4_code", 32'(last_code), 32'd3);
        send_j(); send_j();
        chk("se0x4_eop", eop_n, 32'd0);
        chk("se0x4_bytes", bytes.size(), 32'd1);

        // Reset in DATA after 4 bits, with a strobe pending on the same edge.
        do_reset();
        send_j();
        send_sync();
        send_bits(32'h6, 4);
        rst = 1'b1;
        {dp, dm} = LK;
        checkData = 1'b1;
        @(posedge useClk); #1;
        chk("rst_mid_outputs", 32'(out_now()), 32'h0);
        rst = 1'b0;
        checkData = 1'b0;
        line_k = 1'b0;
        clr_log();
        @(posedge useClk); #1;
        log_outputs();
        chk("rst_mid_quiet", 32'(out_now()), 32'h0);
        send_j();
        send_sync();
        send_bits(32'hD2, 8);
        send_se0(); send_se0(); send_j();
        chk("post_rst_nbytes", bytes.size(), 32'd1);
        chk("post_rst_byte", 32'(byte_at(0)), 32'hD2);
        chk("post_rst_eop", eop_n, 32'd1);
        chk("post_rst_errs", err_n, 32'd0);
        chk("post_rst_count", 32'(rxByteCount), 32'd1);
        chk("eop_err_exclusive", both_n, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nrzi_rx_decoder.md
Name: nrzi_rx_decoder

Overview:
Low-speed USB receive front end: samples the differential pair once per bit time on the checkData strobe, NRZI-decodes, strips stuffed bits, detects SYNC and EOP, and assembles LSB-first bytes. It is the receive-side counterpart of the NRZI transmit block and drives the token/handshake parser with a byte stream plus packet framing and error pulses.

Parameters:
STUFF_LEN, 6, consecutive decoded 1s after which the next bit is a stuffed 0 and is discarded
EOP_SE0_MAX, 3, maximum SE0 bit times accepted before EOP is declared bad
SYNC_PATTERN, 8'h80, decoded SYNC byte as seen in the LSB-first shift register

Ports:
useClk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
checkData  in  1  one-cycle bit-time strobe; line is sampled only when high
dp  in  1  D+ (already synchronised)
dm  in  1  D- (already synchronised)
rxActive  out  1  high from SYNC accepted until EOP/error completes
rxByte  out  8  last assembled byte; holds until next byte
rxByteValid  out  1  one-cycle pulse, rxByte valid
rxEop  out  1  one-cycle pulse on good EOP (SE0 then J)
rxErr  out  1  one-cycle pulse on any receive error
rxErrCode  out  2  valid with rxErr: 0 stuff, 1 sync, 2 partial byte at EOP, 3 bad line (SE1 or SE0 too long)
rxByteCount  out  4  bytes delivered in current packet, saturates at 15, cleared at SYNC accept

Behaviour:
- Line states (low speed): J = dp 0/dm 1, K = dp 1/dm 0, SE0 = 0/0, SE1 = 1/1.
- Reset: all outputs 0, state IDLE, prevLine = J, shift/bit/stuff counters 0. rst overrides checkData; reset mid-packet gives no rxEop and no rxErr.
- All state advances only on cycles with checkData=1; otherwise state holds and the pulse outputs (rxByteValid, rxEop, rxErr) are 0.
- Pulses are registered: they assert in the cycle after the checkData sample that caused them, for exactly one cycle.
- NRZI decode (J/K only): same level as prevLine -> bit 1; change -> bit 0. prevLine updates on every J/K sample.
- FSM states: IDLE, SYNC, DATA, EOP, ERR.
- IDLE: on first K, clear the shift register and the 3-bit bit counter, enter SYNC with that K decoded as 0. SE0/SE1 in IDLE are ignored.
- SYNC: shift 8 decoded bits LSB-first. On the 8th bit, if shift == SYNC_PATTERN: rxActive<=1, stuff counter<=1 (SYNC's final 1 counts toward stuffing), rxByteCount<=0, go to DATA. Otherwise rxErr with code 1, go to ERR. SE0/SE1 in SYNC -> code 1, go to ERR.
- DATA:
  - Stuff counter counts consecutive decoded 1s across byte boundaries.
  - When it reaches STUFF_LEN, the next bit must be 0: it is discarded, not counted, and the counter is cleared. A 1 in that slot -> rxErr code 0, go to ERR.
  - A non-stuffed bit shifts in and increments the bit counter. On the 8th bit: rxByte <= shifted value, rxByteValid pulse, rxByteCount +1 (saturating), bit counter wraps to 0.
- SE0 in DATA (takes priority over any pending stuff check) -> EOP with SE0 count 1. If bit counter != 0 at that moment, flag partial.
- SE1 in any active state -> rxErr code 3, go to ERR.
- EOP:
  - SE0 increments the SE0 count; exceeding EOP_SE0_MAX -> rxErr code 3, go to ERR.
  - J: if partial is set -> rxErr code 2; else rxEop pulse. Either way rxActive<=0, prevLine<=J, go to IDLE.
  - K in EOP -> rxErr code 3, go to ERR.
- ERR: rxActive<=0; wait for 2 consecutive J samples, then IDLE with prevLine=J. No further byte/EOP pulses until the next SYNC.
- rxErr and rxEop are never both asserted in the same cycle. No data is dropped silently except stuffed bits.

Test Plan:
- ACK packet: idle J, SYNC KJKJKJKK, PID 0xD2 NRZI-encoded, SE0 SE0 J -> one rxByteValid with rxByte=0xD2, rxByteCount=1, rxEop one cycle after the J sample, rxActive low after.
- Stuffing: SYNC + data 0xFF 0x01, with stuffed 0s inserted after each run of six 1s (first run includes SYNC's 1) -> bytes 0xFF then 0x01, no rxErr; removing one stuffed transition -> rxErr code 0, no rxEop.
- Bad SYNC: KJKJKJKJ then data -> rxErr code 1, no rxByteValid, returns to IDLE after 2 J samples and accepts the next valid SYNC.
- Partial byte: SYNC + 5 data bits + SE0 SE0 J -> rxErr code 2, no rxEop; SE0 held 4 bit times -> rxErr code 3.
- checkData gaps: insert 3 idle cycles between every strobe for the ACK packet -> identical results, pulses exactly one cycle wide.
- Reset mid-DATA after 4 bits: all outputs 0 next cycle, no rxEop/rxErr; the next clean packet decodes correctly.
